pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised fetch-address generator replacing the combinational next-PC path. Holds the PC and resolves branches with its own comparator.
//  Arbitrates trap/jalr/jal/branch redirects and drives a valid/ready request to instruction memory.
//  Sits between hazard unit/execute stage and IMEM. Adds stall, flush, a pending-redirect buffer and misaligned-target traps.
// PARAMETERS
//  XLEN        32            datapath/address width
//  RESET_VEC   32'h0000_0000 first fetch address after reset
//  IALIGN      32            instruction alignment in bits: 32 (target[1:0] must be 0) or 16 (target[0] must be 0)
// PORTS
//  clk          in   1     clock
//  rstn         in   1     reset, asynchronous, active-high
//  stall        in   1     hazard stall: hold PC, no new request
//  br_valid     in   1     conditional branch in EX
//  br_funct3    in   3     000 beq,001 bne,100 blt,101 bge,110 bltu,111 bgeu
//  br_rs1/rs2   in   XLEN  branch operands
//  ex_pc        in   XLEN  PC of EX-stage instruction
//  ex_imm       in   XLEN  sign-extended immediate
//  jal_valid    in   1     jal in EX: target ex_pc+ex_imm
//  jalr_valid   in   1     jalr in EX: target (jalr_base+ex_imm)&~1
//  jalr_base    in   XLEN  forwarded rs1 value
//  trap_req     in   1     exception/interrupt redirect
//  trap_vec     in   XLEN  trap target (mtvec)
//  imem_valid   out  1     fetch request valid
//  imem_ready   in   1     IMEM accepts request this cycle
//  imem_addr    out  XLEN  fetch address (== pc register)
//  fetch_valid  out  1     registered: accepted request is live (not killed)
//  fetch_pc     out  XLEN  registered address of accepted request
//  flush        out  1     comb: redirect taken this cycle; kill IF/ID
//  misalign     out  1     registered pulse: redirect target misaligned
//  misalign_addr out XLEN  offending target (held until next misalign)
//  bad_funct3   out  1     comb: br_valid with funct3 010/011 (treated not-taken)
// BEHAVIOUR
//  Reset: pc=RESET_VEC, state=BOOT, imem_valid=0, fetch_valid=0, fetch_pc=0, misalign=0, misalign_addr=0, pend_v=0.
//  States: BOOT -> RUN after 1 cycle (imem_valid=0 in BOOT). RUN: imem_valid=!stall. RUN & imem_valid & !imem_ready -> WAIT.
//  WAIT: imem_valid=1, imem_addr stable until imem_ready; then -> RUN. stall is ignored in WAIT (request cannot be withdrawn).
//  Redirect source priority: trap_req > jalr > jal > taken branch. Taken: signed/unsigned compare per funct3, 1 cycle, comb.
//  All adds wrap modulo 2^XLEN. Sequential next = pc + IALIGN/8 (4 or 2).
//  Misaligned jal/jalr/branch target: no redirect; flush=1, pc <= trap_vec, misalign=1 next cycle, misalign_addr<=target. trap_vec never checked.
//  Redirect in RUN (any stall value): flush=1, pc<=target next cycle; request of this cycle, if accepted, has fetch_valid=0.
//  Redirect in WAIT: flush=1, target stored in pend (pend_v=1, higher priority overwrites); on imem_ready, pc<=pend target, pend_v<=0, fetch_valid=0 for that accept.
//  Redirect same cycle as imem_ready in WAIT: applied directly, no pend; accepted fetch killed.
//  Non-redirect accept: fetch_valid<=1, fetch_pc<=imem_addr, pc<=pc+step. No accept: fetch_valid<=0, pc held.
//  Reset asserted mid-WAIT: state and pend discarded immediately; restart at BOOT.
//  flush/bad_funct3 are combinational from EX inputs; all other outputs registered.
// TESTING
//  Reset, imem_ready=1 always -> BOOT 1 cycle, then fetch_pc 0,4,8,C with fetch_valid=1.
//  beq rs1=5 rs2=5 ex_pc=0x10 imm=0x20 -> flush=1, next imem_addr=0x30; blt rs1=-1 rs2=1 taken, bltu same operands not taken.
//  jalr base=0x101 imm=0x2 (IALIGN=32) -> target 0x102 misaligned: misalign=1, misalign_addr=0x102, pc=trap_vec.
//  imem_ready=0 for 3 cycles at addr 0x40 with jal to 0x80 on cycle 2 -> addr stays 0x40, accept killed, next addr 0x80.
//  trap_req and jal same cycle -> pc=trap_vec; stall=1 in RUN -> imem_valid=0, pc held; IALIGN=16 -> step 2.
//  Wrap: pc=0xFFFF_FFFC sequential -> 0x0000_0000; rstn pulse during WAIT -> pend_v cleared, pc=RESET_VEC.

Source files
------------

// File: rtl/pc_gen_unit_if.sv
// Fetch-side handshake between the PC generator and instruction memory,
// plus the registered record of the last accepted fetch.
interface pc_gen_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_valid;
  logic            imem_ready;
  logic [XLEN-1:0] imem_addr;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;

  modport master (
    output imem_valid, imem_addr, fetch_valid, fetch_pc,
    input  imem_ready
  );

  modport slave (
    input  imem_valid, imem_addr, fetch_valid, fetch_pc,
    output imem_ready
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-address generator: holds the PC, resolves EX-stage branches/jumps/traps
// and issues valid/ready fetch requests to instruction memory.
module pc_gen_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  br_rs1,
  input  logic [XLEN-1:0]  br_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             jal_valid,
  input  logic             jalr_valid,
  input  logic [XLEN-1:0]  jalr_base,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vec,
  pc_gen_unit_if.master    imem,
  output logic             flush,
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr,
  output logic             bad_funct3
);

  localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN / 8);

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            pend_v;
  logic [XLEN-1:0] pend_pc;
  logic [1:0]      pend_pri;
  logic            fetch_valid_q;
  logic [XLEN-1:0] fetch_pc_q;

  logic            br_taken;
  logic            redir;
  logic [1:0]      redir_pri;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] dest;
  logic            chk;
  logic            tgt_mis;
  logic [XLEN-1:0] rel_target;
  logic            req;
  logic            accept;

  assign rel_target = ex_pc + ex_imm;

  always_comb begin
    br_taken = 1'b0;
    case (br_funct3)
      3'b000:  br_taken = (br_rs1 == br_rs2);
      3'b001:  br_taken = (br_rs1 != br_rs2);
      3'b100:  br_taken = ($signed(br_rs1) <  $signed(br_rs2));
      3'b101:  br_taken = ($signed(br_rs1) >= $signed(br_rs2));
      3'b110:  br_taken = (br_rs1 <  br_rs2);
      3'b111:  br_taken = (br_rs1 >= br_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  // Priority 3..0 = trap, jalr, jal, branch; the trap vector is trusted as aligned.
  always_comb begin
    redir     = 1'b1;
    redir_pri = 2'd0;
    target    = rel_target;
    chk       = 1'b1;
    if (trap_req) begin
      redir_pri = 2'd3;
      target    = trap_vec;
      chk       = 1'b0;
    end else if (jalr_valid) begin
      redir_pri = 2'd2;
      target    = (jalr_base + ex_imm) & ~XLEN'(1);
    end else if (jal_valid) begin
      redir_pri = 2'd1;
    end else if (!(br_valid && br_taken)) begin
      redir = 1'b0;
      chk   = 1'b0;
    end
    tgt_mis = chk && ((IALIGN == 16) ? target[0] : (target[1:0] != 2'b00));
    dest    = tgt_mis ? trap_vec : target;
  end

  assign flush      = redir;
  assign bad_funct3 = br_valid && (br_funct3[2:1] == 2'b01);

  assign req              = (state == WAIT) || ((state == RUN) && !stall);
  assign accept           = req && imem.imem_ready;
  assign imem.imem_valid  = req;
  assign imem.imem_addr   = pc;
  assign imem.fetch_valid = fetch_valid_q;
  assign imem.fetch_pc    = fetch_pc_q;

  // In WAIT the address is frozen, so redirects are parked in pend until the accept.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state         <= BOOT;
      pc            <= RESET_VEC;
      pend_v        <= 1'b0;
      pend_pc       <= '0;
      pend_pri      <= 2'd0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= redir && tgt_mis;
      if (redir && tgt_mis) misalign_addr <= target;
      if (accept) fetch_pc_q <= pc;
      case (state)
        BOOT: begin
          state         <= RUN;
          fetch_valid_q <= 1'b0;
          if (redir) pc <= dest;
        end
        RUN: begin
          if (redir) begin
            pc            <= dest;
            fetch_valid_q <= 1'b0;
          end else if (accept) begin
            pc            <= pc + STEP;
            fetch_valid_q <= 1'b1;
          end else begin
            fetch_valid_q <= 1'b0;
            if (req) state <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_ready) begin
            state  <= RUN;
            pend_v <= 1'b0;
            if (redir) begin
              pc            <= dest;
              fetch_valid_q <= 1'b0;
            end else if (pend_v) begin
              pc            <= pend_pc;
              fetch_valid_q <= 1'b0;
            end else begin
              pc            <= pc + STEP;
              fetch_valid_q <= 1'b1;
            end
          end else begin
            fetch_valid_q <= 1'b0;
            if (redir && (!pend_v || redir_pri >= pend_pri)) begin
              pend_v   <= 1'b1;
              pend_pc  <= dest;
              pend_pri <= redir_pri;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios with literal expectations, plus a
// transaction-level fetch model compared against the DUT on every falling edge.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, br_valid, jal_valid, jalr_valid, trap_req;
  logic [2:0]  br_funct3;
  logic [31:0] br_rs1, br_rs2, ex_pc, ex_imm, jalr_base, trap_vec;
  logic        flush, misalign, bad_funct3;
  logic [31:0] misalign_addr;
  logic        flush16, mis16, bad16;
  logic [31:0] maddr16;

  int vectors     = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  pc_gen_unit_if #(.XLEN(32)) imem ();
  pc_gen_unit_if #(.XLEN(32)) imem16 ();

  pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(32)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .br_valid(br_valid), .br_funct3(br_funct3), .br_rs1(br_rs1), .br_rs2(br_rs2),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .jal_valid(jal_valid), .jalr_valid(jalr_valid),
    .jalr_base(jalr_base), .trap_req(trap_req), .trap_vec(trap_vec),
    .imem(imem.master), .flush(flush), .misalign(misalign),
    .misalign_addr(misalign_addr), .bad_funct3(bad_funct3)
  );

  // Compressed-ISA instance: free-running sequential fetch only.
  assign imem16.imem_ready = 1'b1;

  pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(16)) dut16 (
    .clk(clk), .rstn(rstn), .stall(1'b0),
    .br_valid(1'b0), .br_funct3(3'b000), .br_rs1(32'h0), .br_rs2(32'h0),
    .ex_pc(32'h0), .ex_imm(32'h0), .jal_valid(1'b0), .jalr_valid(1'b0),
    .jalr_base(32'h0), .trap_req(1'b0), .trap_vec(32'h0),
    .imem(imem16.master), .flush(flush16), .misalign(mis16),
    .misalign_addr(maddr16), .bad_funct3(bad16)
  );

  // Model of the fetch engine: booting, free (request whenever not stalled) or
  // stuck on an unaccepted address with an optional parked redirect.
  logic        m_booting, m_stuck, m_pend_v, m_fv, m_mis;
  logic [31:0] m_pc, m_pend_pc, m_fpc, m_maddr;
  int          m_pend_pri;

  function automatic void model_redirect(output bit r, output logic [31:0] tgt,
                                         output int pri, output bit odd);
    bit taken;
    case (br_funct3)
      3'd0:    taken = (br_rs1 == br_rs2);
      3'd1:    taken = (br_rs1 != br_rs2);
      3'd4:    taken = ($signed(br_rs1) <  $signed(br_rs2));
      3'd5:    taken = ($signed(br_rs1) >= $signed(br_rs2));
      3'd6:    taken = (br_rs1 <  br_rs2);
      3'd7:    taken = (br_rs1 >= br_rs2);
      default: taken = 1'b0;
    endcase
    r = 1'b1;
    if (trap_req)                 begin tgt = trap_vec;                             pri = 3;  end
    else if (jalr_valid)          begin tgt = (jalr_base + ex_imm) & 32'hFFFF_FFFE; pri = 2;  end
    else if (jal_valid)           begin tgt = ex_pc + ex_imm;                       pri = 1;  end
    else if (br_valid && taken)   begin tgt = ex_pc + ex_imm;                       pri = 0;  end
    else                          begin tgt = 32'h0; r = 1'b0;                      pri = -1; end
    odd = r && (pri < 3) && ((tgt % 4) != 0);
  endfunction

  function automatic bit model_valid();
    return !m_booting && (m_stuck || !stall);
  endfunction

  always @(posedge clk or posedge rstn) begin : model
    bit          r, odd, acc;
    int          pri;
    logic [31:0] t, dest;
    if (rstn) begin
      m_booting <= 1'b1; m_stuck <= 1'b0; m_pend_v <= 1'b0; m_pend_pc <= 32'h0;
      m_pend_pri <= 0; m_pc <= 32'h0; m_fv <= 1'b0; m_fpc <= 32'h0;
      m_mis <= 1'b0; m_maddr <= 32'h0;
    end else begin
      model_redirect(r, t, pri, odd);
      dest = odd ? trap_vec : t;
      acc  = model_valid() && imem.imem_ready;
      m_mis <= odd;
      if (odd) m_maddr <= t;
      if (acc) m_fpc <= m_pc;
      if (m_booting) begin
        m_booting <= 1'b0;
        m_fv      <= 1'b0;
        if (r) m_pc <= dest;
      end else if (!m_stuck) begin
        if (r)        begin m_pc <= dest;       m_fv <= 1'b0; end
        else if (acc) begin m_pc <= m_pc + 4;   m_fv <= 1'b1; end
        else          begin m_fv <= 1'b0; if (model_valid()) m_stuck <= 1'b1; end
      end else if (imem.imem_ready) begin
        m_stuck  <= 1'b0;
        m_pend_v <= 1'b0;
        if (r)             begin m_pc <= dest;      m_fv <= 1'b0; end
        else if (m_pend_v) begin m_pc <= m_pend_pc; m_fv <= 1'b0; end
        else               begin m_pc <= m_pc + 4;  m_fv <= 1'b1; end
      end else begin
        m_fv <= 1'b0;
        if (r && (!m_pend_v || pri >= m_pend_pri)) begin
          m_pend_v <= 1'b1; m_pend_pc <= dest; m_pend_pri <= pri;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clearEx();
    br_valid = 0; jal_valid = 0; jalr_valid = 0; trap_req = 0;
    br_funct3 = 3'b000; br_rs1 = 0; br_rs2 = 0; ex_pc = 0; ex_imm = 0; jalr_base = 0;
  endtask

  initial begin : compare
    bit          r, odd;
    int          pri;
    logic [31:0] t;
    forever begin
      @(negedge clk);
      model_redirect(r, t, pri, odd);
      checkOutput("imem_valid", imem.imem_valid, model_valid());
      checkOutput("imem_addr", imem.imem_addr, m_pc);
      checkOutput("fetch_valid", imem.fetch_valid, m_fv);
      if (m_fv) checkOutput("fetch_pc", imem.fetch_pc, m_fpc);
      checkOutput("flush", flush, r);
      checkOutput("bad_funct3", bad_funct3, br_valid && (br_funct3 == 3'd2 || br_funct3 == 3'd3));
      checkOutput("misalign", misalign, m_mis);
      checkOutput("misalign_addr", misalign_addr, m_maddr);
    end
  end

  typedef struct { logic [2:0] f3; bit tk; bit bad; } br_vec_t;
  br_vec_t br_tab[8] = '{
    '{3'b000, 1'b0, 1'b0}, '{3'b001, 1'b1, 1'b0}, '{3'b010, 1'b0, 1'b1}, '{3'b011, 1'b0, 1'b1},
    '{3'b100, 1'b1, 1'b0}, '{3'b101, 1'b0, 1'b0}, '{3'b110, 1'b0, 1'b0}, '{3'b111, 1'b1, 1'b0}
  };

  initial begin
    rstn = 1'b1; stall = 0; trap_vec = 0; imem.imem_ready = 1'b1;
    clearEx();
    applyStimulus(2);
    checkOutput("rst imem_valid", imem.imem_valid, 0);
    checkOutput("rst imem_addr", imem.imem_addr, 32'h0);
    checkOutput("rst fetch_valid", imem.fetch_valid, 0);
    checkOutput("rst misalign", misalign, 0);
    rstn = 1'b0;
    applyStimulus(1);
    checkOutput("boot done valid", imem.imem_valid, 1);
    checkOutput("boot no fetch", imem.fetch_valid, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("seq fetch_valid", imem.fetch_valid, 1);
      checkOutput("seq fetch_pc", imem.fetch_pc, 32'(i * 4));
      checkOutput("ialign16 fetch_pc", imem16.fetch_pc, 32'(i * 2));
    end
    checkOutput("ialign16 flush", {flush16, mis16, bad16}, 0);
    checkOutput("ialign16 maddr", maddr16, 32'h0);

    br_valid = 1; br_funct3 = 3'b000; br_rs1 = 5; br_rs2 = 5; ex_pc = 32'h10; ex_imm = 32'h20;
    #1 checkOutput("beq flush", flush, 1);
    applyStimulus(1);
    clearEx();
    checkOutput("beq target", imem.imem_addr, 32'h30);
    checkOutput("beq killed", imem.fetch_valid, 0);

    br_valid = 1; br_rs1 = 32'hFFFF_FFFF; br_rs2 = 1; ex_pc = 32'h30; ex_imm = 32'h10;
    foreach (br_tab[k]) begin
      br_funct3 = br_tab[k].f3;
      #1;
      checkOutput("branch taken", flush, br_tab[k].tk);
      checkOutput("branch bad_funct3", bad_funct3, br_tab[k].bad);
    end
    br_funct3 = 3'b100;
    applyStimulus(1);
    clearEx();
    checkOutput("blt target", imem.imem_addr, 32'h40);

    imem.imem_ready = 1'b0;
    applyStimulus(1);
    checkOutput("wait addr 1", imem.imem_addr, 32'h40);
    jal_valid = 1; ex_pc = 32'h70; ex_imm = 32'h10;
    #1 checkOutput("wait jal flush", flush, 1);
    applyStimulus(1);
    clearEx();
    checkOutput("wait addr 2", imem.imem_addr, 32'h40);
    applyStimulus(1);
    checkOutput("wait addr 3", imem.imem_addr, 32'h40);
    imem.imem_ready = 1'b1;
    applyStimulus(1);
    checkOutput("pend target", imem.imem_addr, 32'h80);
    checkOutput("pend accept killed", imem.fetch_valid, 0);

    jalr_valid = 1; jalr_base = 32'h101; ex_imm = 32'h2; trap_vec = 32'h200;
    #1 checkOutput("jalr flush", flush, 1);
    applyStimulus(1);
    clearEx();
    checkOutput("misalign pulse", misalign, 1);
    checkOutput("misalign_addr", misalign_addr, 32'h102);
    checkOutput("misalign to trap_vec", imem.imem_addr, 32'h200);
    applyStimulus(1);
    checkOutput("misalign pulse end", misalign, 0);
    checkOutput("misalign_addr held", misalign_addr, 32'h102);

    trap_req = 1; trap_vec = 32'h300; jal_valid = 1; ex_pc = 32'h0; ex_imm = 32'h500;
    applyStimulus(1);
    clearEx();
    checkOutput("trap over jal", imem.imem_addr, 32'h300);

    stall = 1;
    #1 checkOutput("stall no request", imem.imem_valid, 0);
    applyStimulus(2);
    checkOutput("stall pc held", imem.imem_addr, 32'h300);
    checkOutput("stall no fetch", imem.fetch_valid, 0);
    stall = 0;

    jal_valid = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC;
    applyStimulus(1);
    clearEx();
    checkOutput("near top", imem.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1);
    checkOutput("wrap addr", imem.imem_addr, 32'h0);
    checkOutput("wrap fetch_pc", imem.fetch_pc, 32'hFFFF_FFFC);

    applyStimulus(1);
    imem.imem_ready = 1'b0;
    applyStimulus(1);
    jal_valid = 1; ex_pc = 32'h500; ex_imm = 32'h0;
    applyStimulus(1);
    clearEx();
    checkOutput("pre-reset wait addr", imem.imem_addr, 32'h4);
    rstn = 1'b1;
    #1;
    checkOutput("mid-wait reset addr", imem.imem_addr, 32'h0);
    checkOutput("mid-wait reset valid", imem.imem_valid, 0);
    applyStimulus(1);
    rstn = 1'b0; imem.imem_ready = 1'b1;
    applyStimulus(2);
    checkOutput("post-reset fetch_pc", imem.fetch_pc, 32'h0);
    checkOutput("post-reset pend dropped", imem.imem_addr, 32'h4);

    imem.imem_ready = 1'b0;
    applyStimulus(1);
    imem.imem_ready = 1'b1; jal_valid = 1; ex_pc = 32'h600; ex_imm = 32'h0;
    applyStimulus(1);
    clearEx();
    checkOutput("direct wait redirect", imem.imem_addr, 32'h600);
    checkOutput("direct wait killed", imem.fetch_valid, 0);
    applyStimulus(1);
    checkOutput("after redirect fetch", imem.fetch_pc, 32'h600);

    applyStimulus(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
